// File: rtl/sramlike_axi_bridge_if.sv
// ----------------------------------------------------------------------------
// Port bundles for sramlike_axi_bridge.
//
// sram_port_if : cache-side sram-like memory port.
//   master = cache (drives req/wr/size/addr/wdata)
//   slave  = bridge (drives rdata/addr_ok/data_ok/bus_err)
//
// axi_port_if : single-beat AXI4 subset (no id/len/burst/lock/cache/prot;
//   the top-level wrapper ties those off).
//   master = bridge (drives ar*/aw*/w* payload+valid, rready, bready)
//   slave  = memory (drives arready, r*, awready, wready, b*)
//
// Handshake rule on every AXI channel: a transfer happens in the cycle where
// valid & ready are both high; valid, once raised, stays high with a stable
// payload until that cycle, and ready may be raised or dropped freely.
// ----------------------------------------------------------------------------
interface sram_port_if #(
    parameter int ADDR_W = 32
);
    logic              req;
    logic              wr;
    logic [1:0]        size;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    logic [31:0]       rdata;
    logic              addr_ok;
    logic              data_ok;
    logic              bus_err;

    modport master (
        output req, wr, size, addr, wdata,
        input  rdata, addr_ok, data_ok, bus_err
    );

    modport slave (
        input  req, wr, size, addr, wdata,
        output rdata, addr_ok, data_ok, bus_err
    );
endinterface

interface axi_port_if #(
    parameter int ADDR_W = 32
);
    logic [ADDR_W-1:0] araddr;
    logic [2:0]        arsize;
    logic              arvalid;
    logic              arready;
    logic [31:0]       rdata_axi;
    logic [1:0]        rresp;
    logic              rvalid;
    logic              rready;
    logic [ADDR_W-1:0] awaddr;
    logic [2:0]        awsize;
    logic              awvalid;
    logic              awready;
    logic [31:0]       wdata_axi;
    logic [3:0]        wstrb;
    logic              wvalid;
    logic              wready;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready;

    modport master (
        output araddr, arsize, arvalid, rready,
               awaddr, awsize, awvalid, wdata_axi, wstrb, wvalid, bready,
        input  arready, rdata_axi, rresp, rvalid,
               awready, wready, bresp, bvalid
    );

    modport slave (
        input  araddr, arsize, arvalid, rready,
               awaddr, awsize, awvalid, wdata_axi, wstrb, wvalid, bready,
        output arready, rdata_axi, rresp, rvalid,
               awready, wready, bresp, bvalid
    );
endinterface

// File: rtl/sramlike_axi_bridge.sv
// ----------------------------------------------------------------------------
// sramlike_axi_bridge
//
// Turns the data cache's sram-like port (req/addr_ok/data_ok) into single-beat
// AXI read or write transactions, one in flight at a time, in request order.
//
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   sram       : sram_port_if.slave  - cache side
//   axi        : axi_port_if.master  - memory side
//   state_dbg  : current FSM state (0 IDLE, 1 AR, 2 R, 3 AW_W, 4 B)
//
// Parameters:
//   ADDR_W     : address width (only 32 supported)
//   ERR_STICKY : 1 = bus_err held until rst, 0 = one-cycle pulse with the
//                failing data_ok
// ----------------------------------------------------------------------------
module sramlike_axi_bridge #(
    parameter int ADDR_W     = 32,
    parameter bit ERR_STICKY = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    sram_port_if.slave   sram,
    axi_port_if.master   axi,
    output logic [2:0]   state_dbg
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        AR   = 3'd1,
        R    = 3'd2,
        AW_W = 3'd3,
        B    = 3'd4
    } state_t;

    state_t            state_q,   state_d;
    logic [ADDR_W-1:0] addr_q,    addr_d;
    logic [1:0]        size_q,    size_d;
    logic              wr_q,      wr_d;
    logic [31:0]       wdata_q,   wdata_d;
    logic [3:0]        wstrb_q,   wstrb_d;
    logic              arvalid_q, arvalid_d;
    logic              rready_q,  rready_d;
    logic              awvalid_q, awvalid_d;
    logic              wvalid_q,  wvalid_d;
    logic              bready_q,  bready_d;
    logic              bus_err_q, bus_err_d;

    logic              r_fire;
    logic              b_fire;
    logic              err_now;
    logic              aw_ok;
    logic              w_ok;
    logic [3:0]        strb_new;

    // Byte lanes for the incoming request; size=3 is illegal and enables none.
    always_comb begin
        strb_new = 4'b0000;
        case (sram.size)
            2'd0:    strb_new = 4'b0001 << sram.addr[1:0];
            2'd1:    strb_new = sram.addr[1] ? 4'b1100 : 4'b0011;
            2'd2:    strb_new = 4'b1111;
            default: strb_new = 4'b0000;
        endcase
    end

    assign r_fire  = rready_q & axi.rvalid;
    assign b_fire  = bready_q & axi.bvalid;
    assign err_now = (r_fire & (axi.rresp != 2'b00)) |
                     (b_fire & (axi.bresp != 2'b00));

    // A channel counts as done if it finished earlier or finishes this cycle.
    assign aw_ok = ~awvalid_q | axi.awready;
    assign w_ok  = ~wvalid_q  | axi.wready;

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        size_d    = size_q;
        wr_d      = wr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        arvalid_d = arvalid_q;
        rready_d  = rready_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        bready_d  = bready_q;
        bus_err_d = bus_err_q;

        case (state_q)
            IDLE: begin
                if (sram.req) begin
                    addr_d  = sram.addr;
                    size_d  = sram.size;
                    wr_d    = sram.wr;
                    wdata_d = sram.wdata;
                    wstrb_d = strb_new;
                    if (sram.wr) begin
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        state_d   = AW_W;
                    end else begin
                        arvalid_d = 1'b1;
                        state_d   = AR;
                    end
                end
            end
            AR: begin
                if (axi.arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = R;
                end
            end
            R: begin
                if (axi.rvalid) begin
                    rready_d = 1'b0;
                    state_d  = IDLE;
                end
            end
            AW_W: begin
                if (awvalid_q && axi.awready) awvalid_d = 1'b0;
                if (wvalid_q && axi.wready)   wvalid_d  = 1'b0;
                if (aw_ok && w_ok) begin
                    awvalid_d = 1'b0;
                    wvalid_d  = 1'b0;
                    bready_d  = 1'b1;
                    state_d   = B;
                end
            end
            B: begin
                if (axi.bvalid) begin
                    bready_d = 1'b0;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (ERR_STICKY && err_now) bus_err_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            size_q    <= '0;
            wr_q      <= 1'b0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            size_q    <= size_d;
            wr_q      <= wr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            arvalid_q <= arvalid_d;
            rready_q  <= rready_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            bready_q  <= bready_d;
            bus_err_q <= bus_err_d;
        end
    end

    // Cache side. addr_ok only exists in IDLE, so it can never coincide with
    // data_ok, and the next request lands at the earliest one cycle later.
    assign sram.addr_ok = ~rst & (state_q == IDLE) & sram.req;
    assign sram.data_ok = ~rst & (wr_q ? b_fire : r_fire);
    assign sram.rdata   = (~rst & ~wr_q & r_fire) ? axi.rdata_axi : 32'h0;
    assign sram.bus_err = ~rst & (bus_err_q | err_now);

    // AXI side: payloads come straight from the holding registers so they
    // stay stable while the matching valid is pending.
    assign axi.araddr    = addr_q;
    assign axi.arsize    = {1'b0, size_q};
    assign axi.arvalid   = arvalid_q;
    assign axi.rready    = rready_q;
    assign axi.awaddr    = addr_q;
    assign axi.awsize    = {1'b0, size_q};
    assign axi.awvalid   = awvalid_q;
    assign axi.wdata_axi = wdata_q;
    assign axi.wstrb     = wstrb_q;
    assign axi.wvalid    = wvalid_q;
    assign axi.bready    = bready_q;

    assign state_dbg = state_q;

endmodule

// File: tb/tb_sramlike_axi_bridge.sv
module tb_sramlike_axi_bridge;

    logic       clk;
    logic       rst;
    logic [2:0] state_dbg;

    int n_vec = 0;
    int n_bad = 0;

    sram_port_if #(.ADDR_W(32)) sram ();
    axi_port_if  #(.ADDR_W(32)) axi ();

    sramlike_axi_bridge #(.ADDR_W(32), .ERR_STICKY(1'b1)) dut (
        .clk       (clk),
        .rst       (rst),
        .sram      (sram),
        .axi       (axi),
        .state_dbg (state_dbg)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish, observed timeout, expected completion");
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks ----------------
    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Let combinational outputs settle after changing inputs.
    task automatic settle();
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        sram.req       = 1'b0;
        sram.wr        = 1'b0;
        sram.size      = 2'd0;
        sram.addr      = 32'h0;
        sram.wdata     = 32'h0;
        axi.arready    = 1'b0;
        axi.rdata_axi  = 32'h0;
        axi.rresp      = 2'b00;
        axi.rvalid     = 1'b0;
        axi.awready    = 1'b0;
        axi.wready     = 1'b0;
        axi.bresp      = 2'b00;
        axi.bvalid     = 1'b0;
    endtask

    // Zero-wait write: accept, both address/data handshakes next cycle, bvalid after.
    task automatic do_write(input string tag, input logic [31:0] a, input logic [1:0] sz,
                            input logic [31:0] wd, input logic [3:0] exp_strb);
        sram.req = 1'b1; sram.wr = 1'b1; sram.addr = a; sram.size = sz; sram.wdata = wd;
        settle();
        chk({tag, ".addr_ok"}, {31'b0, sram.addr_ok}, 32'd1);
        tick();
        sram.req = 1'b0; axi.awready = 1'b1; axi.wready = 1'b1;
        settle();
        chk({tag, ".awvalid"}, {31'b0, axi.awvalid}, 32'd1);
        chk({tag, ".wvalid"},  {31'b0, axi.wvalid},  32'd1);
        chk({tag, ".awaddr"},  axi.awaddr, a);
        chk({tag, ".wstrb"},   {28'b0, axi.wstrb}, {28'b0, exp_strb});
        chk({tag, ".wdata"},   axi.wdata_axi, wd);
        tick();
        axi.awready = 1'b0; axi.wready = 1'b0; axi.bvalid = 1'b1;
        settle();
        chk({tag, ".data_ok"}, {31'b0, sram.data_ok}, 32'd1);
        tick();
        axi.bvalid = 1'b0;
        settle();
        chk({tag, ".idle"}, {29'b0, state_dbg}, 32'd0);
    endtask

    // Zero-wait read.
    task automatic do_read(input string tag, input logic [31:0] a, input logic [31:0] rd);
        sram.req = 1'b1; sram.wr = 1'b0; sram.addr = a; sram.size = 2'd2;
        settle();
        chk({tag, ".addr_ok"}, {31'b0, sram.addr_ok}, 32'd1);
        tick();
        sram.req = 1'b0; axi.arready = 1'b1;
        settle();
        chk({tag, ".arvalid"}, {31'b0, axi.arvalid}, 32'd1);
        chk({tag, ".araddr"},  axi.araddr, a);
        chk({tag, ".arsize"},  {29'b0, axi.arsize}, 32'd2);
        tick();
        axi.arready = 1'b0; axi.rvalid = 1'b1; axi.rdata_axi = rd; axi.rresp = 2'b00;
        settle();
        chk({tag, ".data_ok"}, {31'b0, sram.data_ok}, 32'd1);
        chk({tag, ".rdata"},   sram.rdata, rd);
        tick();
        axi.rvalid = 1'b0;
        settle();
        chk({tag, ".idle"},    {29'b0, state_dbg}, 32'd0);
        chk({tag, ".data_ok0"}, {31'b0, sram.data_ok}, 32'd0);
    endtask

    // ---------------- scoreboard expectations for byte strobes ----------------
    logic [3:0] exp_q[$];

    logic [31:0] addr_hold;

    initial begin
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        settle();
        chk("rst.state",   {29'b0, state_dbg}, 32'd0);
        chk("rst.arvalid", {31'b0, axi.arvalid}, 32'd0);
        chk("rst.awvalid", {31'b0, axi.awvalid}, 32'd0);
        chk("rst.wvalid",  {31'b0, axi.wvalid}, 32'd0);
        chk("rst.bus_err", {31'b0, sram.bus_err}, 32'd0);
        chk("rst.addr_ok", {31'b0, sram.addr_ok}, 32'd0);

        // Read, zero wait
        do_read("rd0", 32'h1000_0040, 32'hDEAD_BEEF);

        // Write, skewed handshakes: wready at T1, awready at T3, bvalid at T5
        sram.req = 1'b1; sram.wr = 1'b1; sram.addr = 32'h2000_0006; sram.size = 2'd1;
        sram.wdata = 32'hAABB_0000;
        settle();
        chk("skw.T0.addr_ok", {31'b0, sram.addr_ok}, 32'd1);
        tick();
        sram.req = 1'b0; axi.wready = 1'b1;
        settle();
        chk("skw.T1.wvalid",  {31'b0, axi.wvalid}, 32'd1);
        chk("skw.T1.awvalid", {31'b0, axi.awvalid}, 32'd1);
        chk("skw.T1.wstrb",   {28'b0, axi.wstrb}, 32'hC);
        chk("skw.T1.awsize",  {29'b0, axi.awsize}, 32'd1);
        chk("skw.T1.awaddr",  axi.awaddr, 32'h2000_0006);
        chk("skw.T1.wdata",   axi.wdata_axi, 32'hAABB_0000);
        tick();
        axi.wready = 1'b0;
        settle();
        chk("skw.T2.wvalid",  {31'b0, axi.wvalid}, 32'd0);
        chk("skw.T2.awvalid", {31'b0, axi.awvalid}, 32'd1);
        tick();
        axi.awready = 1'b1;
        settle();
        chk("skw.T3.awvalid", {31'b0, axi.awvalid}, 32'd1);
        chk("skw.T3.state",   {29'b0, state_dbg}, 32'd3);
        tick();
        axi.awready = 1'b0;
        settle();
        chk("skw.T4.state",   {29'b0, state_dbg}, 32'd4);
        chk("skw.T4.bready",  {31'b0, axi.bready}, 32'd1);
        chk("skw.T4.awvalid", {31'b0, axi.awvalid}, 32'd0);
        chk("skw.T4.data_ok", {31'b0, sram.data_ok}, 32'd0);
        tick();
        axi.bvalid = 1'b1;
        settle();
        chk("skw.T5.data_ok", {31'b0, sram.data_ok}, 32'd1);
        chk("skw.T5.bus_err", {31'b0, sram.bus_err}, 32'd0);
        tick();
        axi.bvalid = 1'b0;
        settle();
        chk("skw.T6.state",   {29'b0, state_dbg}, 32'd0);

        // Byte strobes, plus the illegal size=3 case
        exp_q.push_back(4'b0001);
        exp_q.push_back(4'b0010);
        exp_q.push_back(4'b0100);
        exp_q.push_back(4'b1000);
        for (int i = 0; i < 4; i++) begin
            logic [3:0] e;
            e = exp_q.pop_front();
            do_write($sformatf("byte%0d", i), 32'h3000_0000 + 32'(i), 2'd0,
                     32'h11 << (8 * i), e);
        end
        do_write("half_lo", 32'h3000_0010, 2'd1, 32'h0000_5566, 4'b0011);
        do_write("size3",   32'h3000_0020, 2'd3, 32'h0123_4567, 4'b0000);

        // Back-to-back: write data_ok at Tn with a read request already pending
        sram.req = 1'b1; sram.wr = 1'b1; sram.addr = 32'h4000_0100; sram.size = 2'd2;
        sram.wdata = 32'hCAFE_F00D;
        settle();
        chk("b2b.T0.addr_ok", {31'b0, sram.addr_ok}, 32'd1);
        tick();
        sram.req = 1'b0; axi.awready = 1'b1; axi.wready = 1'b1;
        settle();
        chk("b2b.T1.wstrb", {28'b0, axi.wstrb}, 32'hF);
        tick();
        axi.awready = 1'b0; axi.wready = 1'b0; axi.bvalid = 1'b1;
        sram.req = 1'b1; sram.wr = 1'b0; sram.addr = 32'h4000_0200; sram.size = 2'd2;
        settle();
        chk("b2b.Tn.data_ok", {31'b0, sram.data_ok}, 32'd1);
        chk("b2b.Tn.addr_ok", {31'b0, sram.addr_ok}, 32'd0);
        tick();
        axi.bvalid = 1'b0;
        settle();
        chk("b2b.Tn1.addr_ok", {31'b0, sram.addr_ok}, 32'd1);
        chk("b2b.Tn1.arvalid", {31'b0, axi.arvalid}, 32'd0);
        tick();
        sram.req = 1'b0; axi.arready = 1'b1;
        settle();
        chk("b2b.Tn2.arvalid", {31'b0, axi.arvalid}, 32'd1);
        chk("b2b.Tn2.araddr",  axi.araddr, 32'h4000_0200);
        tick();
        axi.arready = 1'b0; axi.rvalid = 1'b1; axi.rdata_axi = 32'h1234_5678;
        settle();
        chk("b2b.rdata", sram.rdata, 32'h1234_5678);
        tick();
        axi.rvalid = 1'b0;

        // Stall with changing addr input, then an error response
        addr_hold = 32'h5000_0010;
        sram.req = 1'b1; sram.wr = 1'b0; sram.addr = addr_hold; sram.size = 2'd2;
        settle();
        chk("stl.addr_ok", {31'b0, sram.addr_ok}, 32'd1);
        tick();
        sram.req = 1'b0;
        for (int i = 0; i < 5; i++) begin
            sram.addr = $urandom_range(32'h0FFF_FFFF, 0);
            settle();
            chk($sformatf("stl.c%0d.araddr", i), axi.araddr, addr_hold);
            chk($sformatf("stl.c%0d.arvalid", i), {31'b0, axi.arvalid}, 32'd1);
            tick();
        end
        axi.arready = 1'b1;
        settle();
        chk("stl.araddr_hs", axi.araddr, addr_hold);
        tick();
        axi.arready = 1'b0; axi.rvalid = 1'b1; axi.rresp = 2'b10; axi.rdata_axi = 32'h0BAD_0BAD;
        settle();
        chk("err.data_ok", {31'b0, sram.data_ok}, 32'd1);
        chk("err.bus_err", {31'b0, sram.bus_err}, 32'd1);
        tick();
        axi.rvalid = 1'b0; axi.rresp = 2'b00;
        settle();
        chk("err.sticky1", {31'b0, sram.bus_err}, 32'd1);
        do_read("rd_after_err", 32'h5000_0020, 32'h7777_8888);
        chk("err.sticky2", {31'b0, sram.bus_err}, 32'd1);

        // Reset while in B
        sram.req = 1'b1; sram.wr = 1'b1; sram.addr = 32'h6000_0000; sram.size = 2'd2;
        sram.wdata = 32'h5A5A_5A5A;
        settle();
        tick();
        sram.req = 1'b0; axi.awready = 1'b1; axi.wready = 1'b1;
        settle();
        tick();
        axi.awready = 1'b0; axi.wready = 1'b0;
        settle();
        chk("rmw.inB", {29'b0, state_dbg}, 32'd4);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        settle();
        chk("rmw.state",   {29'b0, state_dbg}, 32'd0);
        chk("rmw.valids",  {29'b0, axi.arvalid, axi.awvalid, axi.wvalid}, 32'd0);
        chk("rmw.readies", {30'b0, axi.rready, axi.bready}, 32'd0);
        chk("rmw.bus_err", {31'b0, sram.bus_err}, 32'd0);
        do_read("rd_after_rst", 32'h6000_0040, 32'h0F0F_F0F0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/sramlike_axi_bridge.md
Name: sramlike_axi_bridge

Overview:
- Downstream neighbour of the 2-way write-back data cache.
- Converts the cache's sram-like memory port (req/addr_ok/data_ok) into single-beat AXI read and write transactions.
- Holds at most one transaction in flight.
- Serves read misses (RM) and dirty-line write-backs (WM) in strict request order. Sits between the cache and the top-level AXI wrapper, which ties off id/len/burst/lock/cache/prot.

Parameters:
- ADDR_W, 32, address width. Only 32 is supported.
- ERR_STICKY, 1, controls bus_err. 1: bus_err stays high until rst. 0: bus_err pulses for one cycle with the failing data_ok.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- req  in  1  sram-like request; held by cache until addr_ok
- wr  in  1  1 = write, 0 = read
- size  in  2  0 = byte, 1 = half, 2 = word
- addr  in  32  byte address
- wdata  in  32  write data
- rdata  out  32  read data; valid when data_ok & read
- addr_ok  out  1  request accepted
- data_ok  out  1  transaction complete
- bus_err  out  1  slave returned nonzero resp
- araddr  out  32  AXI read address
- arsize  out  3  {1'b0,size}
- arvalid  out  1
- arready  in  1
- rdata_axi  in  32
- rresp  in  2
- rvalid  in  1
- rready  out  1
- awaddr  out  32
- awsize  out  3  {1'b0,size}
- awvalid  out  1
- awready  in  1
- wdata_axi  out  32
- wstrb  out  4
- wvalid  out  1
- wready  in  1
- bresp  in  2
- bvalid  in  1
- bready  out  1

Behaviour:

States: IDLE, AR, R, AW_W, B.

- **IDLE**
  - addr_ok = req, combinational; no other cycle asserts addr_ok.
  - On req, latch addr, size, wr, wdata and wstrb into holding registers.
  - Next state: AR if wr=0, AW_W if wr=1.
- **AR**
  - arvalid=1; araddr/arsize come from the latched values.
  - On arready, go to R.
- **R**
  - rready=1.
  - On rvalid: data_ok=1, rdata=rdata_axi (combinational passthrough), go to IDLE.
- **AW_W**
  - awvalid=~aw_done, wvalid=~w_done.
  - aw_done sets on awvalid&awready; w_done sets on wvalid&wready.
  - Handshakes may complete in either order or in the same cycle.
  - When both are done (counting the current cycle), go to B and clear both flags.
- **B**
  - bready=1.
  - On bvalid: data_ok=1, go to IDLE.

wstrb encoding:
- size=0: 4'b0001 << addr[1:0].
- size=1: addr[1] ? 4'b1100 : 4'b0011.
- size=2: 4'b1111.
- size=3: 4'b0000. This is illegal; the transaction is still issued.

wdata_axi = latched wdata, unshifted. The cache presents it lane-aligned.

Handshake and timing rules:
- Valids never drop before ready.
- addr/araddr/awaddr stay stable from acceptance until the matching handshake.
- addr_ok is 0 in any cycle where data_ok=1. A new request is accepted no earlier than the cycle after data_ok.
- Minimum latency: req accepted at T0 → arvalid at T1 → data_ok at T2 (arready at T1, rvalid at T2). Writes are the same with awready=wready=1 at T1 and bvalid at T2.

Errors:
- rresp≠0 or bresp≠0 still completes the transaction with data_ok.
- The error sets bus_err per ERR_STICKY.

Reset:
- All outputs are 0 and state is IDLE.
- Holding registers and flags are cleared.
- rst mid-transaction aborts immediately. Any AXI slave must be reset on the same cycle.

Test Plan:
- **Read, zero wait:** req=1, wr=0, addr=0x1000_0040, size=2, arready=1, rvalid at the next cycle with 0xDEADBEEF → addr_ok at T0, arvalid at T1, data_ok and rdata=0xDEADBEEF at T2, then IDLE.
- **Write, skewed handshakes:** wr=1, addr=0x2000_0006, size=1, wdata=0xAABB0000. wready at T1, awready at T3, bvalid at T5 → wstrb=4'b1100, wvalid drops after T1, awvalid held until T3, data_ok at T5.
- **Byte strobes:** four writes, size=0, addr[1:0]=0..3 → wstrb = 0001, 0010, 0100, 1000.
- **Back-to-back WM→RM:** write completes with data_ok at Tn while req is already high → addr_ok=0 at Tn, addr_ok=1 at Tn+1, read issued at Tn+2.
- **Stall and error:** arready low for 5 cycles with a changing addr input → araddr stays stable. rresp=2'b10 → data_ok=1 and bus_err=1, held with ERR_STICKY=1 until rst.
- **Reset mid-write:** rst asserted while in B → the next cycle has all valids/readies at 0 and state IDLE; a following read completes normally.
